// File: rtl/bcd_to_binary.sv
// Sequential 4-digit packed BCD to binary converter (reverse double-dabble, one step per clock).
// Optional macro BCD_INVALID_CHECK_EN adds the err output and forces value=0 for digits > 9.
module bcd_to_binary #(
    parameter int BIN_W = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       thousands,
    input  logic [3:0]       hundreds,
    input  logic [3:0]       tens,
    input  logic [3:0]       ones,
    output logic             busy,
    output logic             done,
`ifdef BCD_INVALID_CHECK_EN
    output logic             err,
`endif
    output logic [BIN_W-1:0] value
);
    localparam int ITER = 14;
    localparam int SR_W = 16 + ITER;

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state_q;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [3:0]        cnt_q;
    logic              busy_q, done_q;
    logic [BIN_W-1:0]  value_q;
`ifdef BCD_INVALID_CHECK_EN
    logic              inv_q, err_q;
    logic              inv_d;
    assign inv_d = (thousands > 4'd9) | (hundreds > 4'd9) | (tens > 4'd9) | (ones > 4'd9);
    assign err   = err_q;
`endif

    // Shift right, then pull each BCD digit back into range; digits never borrow across fields.
    always_comb begin
        sr_d = {1'b0, sr_q[SR_W-1:1]};
        for (int d = 0; d < 4; d++) begin
            if (sr_d[ITER + 4*d +: 4] >= 4'd8)
                sr_d[ITER + 4*d +: 4] = sr_d[ITER + 4*d +: 4] - 4'd3;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            value_q <= '0;
`ifdef BCD_INVALID_CHECK_EN
            inv_q   <= 1'b0;
            err_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sr_q    <= {thousands, hundreds, tens, ones, {ITER{1'b0}}};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CONV;
`ifdef BCD_INVALID_CHECK_EN
                        inv_q   <= inv_d;
`endif
                    end
                end
                CONV: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'(ITER - 1)) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`ifdef BCD_INVALID_CHECK_EN
                        err_q   <= inv_q;
                        value_q <= inv_q ? '0 : BIN_W'(sr_d[ITER-1:0]);
`else
                        value_q <= BIN_W'(sr_d[ITER-1:0]);
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign value = value_q;
endmodule

// File: tb/tb_bcd_to_binary.sv
// Randomized self-checking bench for bcd_to_binary against a decimal-arithmetic latency model.
module tb_bcd_to_binary;
    localparam int BIN_W = 16;

    logic             clk = 1'b0;
    logic             reset, start;
    logic [3:0]       th, hu, te, on;
    logic             busy, done;
    logic [BIN_W-1:0] value;
`ifdef BCD_INVALID_CHECK_EN
    logic             err;
`endif

    bcd_to_binary #(.BIN_W(BIN_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .thousands(th), .hundreds(hu), .tens(te), .ones(on),
        .busy(busy), .done(done),
`ifdef BCD_INVALID_CHECK_EN
        .err(err),
`endif
        .value(value)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int accepts = 0, dones = 0;

    // Model: accepted at edge k -> done/value at edge k+14, busy in between.
    int m_rem = 0, m_val = 0, m_pend = 0;
    bit m_done = 0, m_err = 0, m_perr = 0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_rem = 0; m_done = 0; m_val = 0; m_err = 0;
        end else begin
            m_done = 0;
            if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) begin
                    m_done = 1;
`ifdef BCD_INVALID_CHECK_EN
                    m_err = m_perr;
                    m_val = m_perr ? 0 : m_pend;
`else
                    m_val = m_pend;
`endif
                end
            end else if (start) begin
                m_rem  = 14;
                m_pend = int'(th) * 1000 + int'(hu) * 100 + int'(te) * 10 + int'(on);
                m_perr = (th > 9) || (hu > 9) || (te > 9) || (on > 9);
                accepts++;
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (busy !== (m_rem > 0) || done !== m_done || value !== BIN_W'(m_val)
`ifdef BCD_INVALID_CHECK_EN
            || err !== m_err
`endif
           ) begin
            miscompares++;
            $display("FAIL cycle_check t=%0t busy=%b want %b done=%b want %b value=%0d want %0d",
                     $time, busy, (m_rem > 0), done, m_done, value, m_val);
        end
        if (done === 1'b1) dones++;
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input int a, b, c, d);
        @(negedge clk);
        th = 4'(a); hu = 4'(b); te = 4'(c); on = 4'(d); start = 1'b1;
    endtask

    // Counts negedges from the start-assert negedge until done is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                start = 1'b0;
                th = 4'($urandom_range(0, 9)); hu = 4'($urandom_range(0, 9));
                te = 4'($urandom_range(0, 9)); on = 4'($urandom_range(0, 9));
            end
        end while (done !== 1'b1 && lat < 40);
    endtask

    task automatic convert(input int a, b, c, d, input string name, input int exp);
        int lat;
        pulse_start(a, b, c, d);
        wait_done(lat);
        chk({name, "_latency"}, lat, 15);
        chk(name, int'(value), exp);
    endtask

    initial begin
        int lat, n, v;
        reset = 1'b1; start = 1'b0; th = 0; hu = 0; te = 0; on = 0;
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_value", int'(value), 0);
        reset = 1'b0;

        convert(9, 9, 9, 9, "v9999", 9999);
        chk("v9999_hex", int'(value), 'h270F);
        convert(0, 0, 0, 0, "v0", 0);
        convert(1, 2, 3, 4, "v1234", 1234);
        convert(0, 0, 0, 8, "v8", 8);
        convert(1, 0, 0, 0, "v1000", 1000);

        // start while busy is ignored; start held in the done cycle is accepted
        pulse_start(3, 0, 0, 7);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        th = 5; hu = 5; te = 5; on = 5; start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        chk("busy_start_ignored", int'(value), 3007);
        th = 0; hu = 0; te = 4; on = 2; start = 1'b1;
        wait_done(lat);
        chk("b2b_latency", lat, 15);
        chk("b2b_value", int'(value), 42);

        // reset mid-conversion
        pulse_start(1, 2, 3, 4);
        repeat (7) @(negedge clk);
        start = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_done", int'(done), 0);
        chk("midreset_value", int'(value), 0);
        @(negedge clk); reset = 1'b0;
        n = 0;
        repeat (20) begin @(negedge clk); if (done === 1'b1) n++; end
        chk("midreset_no_done", n, 0);
        convert(5, 6, 7, 8, "after_reset", 5678);

`ifdef BCD_INVALID_CHECK_EN
        convert(0, 0, 10, 1, "invalid_value", 0);
        chk("invalid_err", int'(err), 1);
        convert(0, 0, 1, 0, "valid_value", 10);
        chk("valid_err", int'(err), 0);
`endif

        // boundaries and random values with random gaps
        convert(9, 9, 9, 0, "v9990", 9990);
        convert(1, 0, 0, 9, "v1009", 1009);
        for (int i = 0; i < 300; i++) begin
            v = $urandom_range(0, 9999);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            convert(v / 1000, (v / 100) % 10, (v / 10) % 10, v % 10, "sweep", v);
        end

        // free-running random start/digits, checked cycle by cycle by the model
        @(negedge clk);
        accepts = 0; dones = 0;
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 3) == 0);
            th = 4'($urandom_range(0, 9)); hu = 4'($urandom_range(0, 9));
            te = 4'($urandom_range(0, 9)); on = 4'($urandom_range(0, 9));
            @(negedge clk);
        end
        start = 1'b0;
        repeat (20) @(negedge clk);
        chk("done_count_eq_accepts", dones, accepts);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
